// File: rtl/dmem_resp.sv
// Memory-side responder for the core's dat_* port: byte-enabled SRAM with one-cycle
// registered reads, plus an MMIO window holding TOHOST, a cycle counter and a write counter.
module dmem_resp #(
  parameter int          AW        = 8,
  parameter logic [15:0] MMIO_BASE = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] dat_a,
  input  logic [3:0]  dat_we,
  input  logic [31:0] dat_wd,
  input  logic [3:0]  dat_re,
  output logic [31:0] dat_rd,
  output logic        done,
  output logic [31:0] exit_code
);

  localparam int         DEPTH      = 2 ** AW;
  localparam logic [5:0] OFF_TOHOST = 6'd0;
  localparam logic [5:0] OFF_CYCLE  = 6'd1;
  localparam logic [5:0] OFF_WRCNT  = 6'd2;

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_cycle;
  logic [31:0] r_wrcnt;

  logic          w_is_mmio;
  logic          w_wr;
  logic          w_sram_wr;
  logic          w_tohost_wr;
  logic [AW-1:0] w_idx;
  logic [5:0]    w_off;
  logic [31:0]   w_mem_word;
  logic [31:0]   w_sram_rdata;
  logic [31:0]   w_mmio_rdata;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_is_mmio   = (dat_a[15:8] == MMIO_BASE[15:8]);
  assign w_wr        = |dat_we;
  assign w_sram_wr   = w_wr && !w_is_mmio;
  assign w_tohost_wr = w_wr && w_is_mmio && (w_off == OFF_TOHOST);
  assign w_idx       = dat_a[AW+1:2];
  assign w_off       = dat_a[7:2];
  assign w_mem_word  = r_mem[w_idx];
  assign w_unused    = &{1'b0, dat_a[1:0]};

  // Write-first merge: a lane written this cycle returns the incoming byte.
  always_comb begin
    w_sram_rdata = w_mem_word;
    for (int n = 0; n < 4; n++) begin
      if (dat_we[n]) w_sram_rdata[8*n +: 8] = dat_wd[8*n +: 8];
    end
  end

  always_comb begin
    w_mmio_rdata = '0;
    case (w_off)
      OFF_CYCLE: w_mmio_rdata = r_cycle;
      OFF_WRCNT: w_mmio_rdata = r_wrcnt;
      default:   w_mmio_rdata = '0;
    endcase
  end

  assign w_rdata = w_is_mmio ? w_mmio_rdata : w_sram_rdata;

  // NOTE: the SRAM array has no reset so it maps onto RAM primitives and keeps its
  // contents across reset; the explicit rst term drops a request on a reset edge.
  always_ff @(posedge clk) begin
    if (w_sram_wr && !rst) begin
      for (int n = 0; n < 4; n++) begin
        if (dat_we[n]) r_mem[w_idx][8*n +: 8] <= dat_wd[8*n +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_rd    <= '0;
      done      <= 1'b0;
      exit_code <= '0;
      r_cycle   <= '0;
      r_wrcnt   <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_sram_wr && (r_wrcnt != 32'hFFFF_FFFF)) r_wrcnt <= r_wrcnt + 32'd1;
      if (w_tohost_wr) begin
        done      <= 1'b1;
        exit_code <= dat_wd;
      end
      // Disabled read lanes hold their previous byte.
      for (int n = 0; n < 4; n++) begin
        if (dat_re[n]) dat_rd[8*n +: 8] <= w_rdata[8*n +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: a vector table for single-cycle behaviour, then
// hand-written sequences for counter wrap/saturation and reset in mid-run.
module tb_dmem_resp;

  logic        clk;
  logic        rst;
  logic [15:0] dat_a;
  logic [3:0]  dat_we;
  logic [31:0] dat_wd;
  logic [3:0]  dat_re;
  logic [31:0] dat_rd;
  logic        done;
  logic [31:0] exit_code;

  int n_checks = 0;
  int n_errors = 0;

  dmem_resp dut (
    .clk       (clk),
    .rst       (rst),
    .dat_a     (dat_a),
    .dat_we    (dat_we),
    .dat_wd    (dat_wd),
    .dat_re    (dat_re),
    .dat_rd    (dat_rd),
    .done      (done),
    .exit_code (exit_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [3:0]  we;
    logic [31:0] wd;
    logic [3:0]  re;
    logic [31:0] rd;
    logic        done;
    logic [31:0] exit_code;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Presents one request, lets one rising edge sample it, then idles the port #1 later.
  task automatic apply(input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd,
                       input logic [3:0] re);
    dat_a  = a;
    dat_we = we;
    dat_wd = wd;
    dat_re = re;
    @(posedge clk);
    #1;
    dat_a  = '0;
    dat_we = '0;
    dat_wd = '0;
    dat_re = '0;
  endtask

  initial begin
    // Edge numbers below count from reset release; WRCNT/CYCLE values are pre-increment.
    vecs[0]  = '{16'h0010, 4'hF, 32'hDEADBEEF, 4'h0, 32'h00000000, 1'b0, 32'h0};
    vecs[1]  = '{16'h0010, 4'h0, 32'h00000000, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[2]  = '{16'h0010, 4'h2, 32'h0000AA00, 4'h0, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[3]  = '{16'h0010, 4'h0, 32'h00000000, 4'h3, 32'hDEADAAEF, 1'b0, 32'h0};
    vecs[4]  = '{16'h0410, 4'hF, 32'h11223344, 4'hF, 32'h11223344, 1'b0, 32'h0};
    vecs[5]  = '{16'h0010, 4'h0, 32'h00000000, 4'hF, 32'h11223344, 1'b0, 32'h0};
    vecs[6]  = '{16'hFF08, 4'h0, 32'h00000000, 4'hF, 32'h00000003, 1'b0, 32'h0};
    vecs[7]  = '{16'hFF0C, 4'h0, 32'h00000000, 4'hF, 32'h00000000, 1'b0, 32'h0};
    vecs[8]  = '{16'h0000, 4'hF, 32'hCAFEF00D, 4'h0, 32'h00000000, 1'b0, 32'h0};
    vecs[9]  = '{16'hFF04, 4'h0, 32'h00000000, 4'hF, 32'h00000009, 1'b0, 32'h0};
    vecs[10] = '{16'h0300, 4'hF, 32'h5A5A5A5A, 4'h0, 32'h00000009, 1'b0, 32'h0};
    vecs[11] = '{16'hFF08, 4'hF, 32'hFFFFFFFF, 4'h0, 32'h00000009, 1'b0, 32'h0};
    vecs[12] = '{16'hFF08, 4'h0, 32'h00000000, 4'hF, 32'h00000005, 1'b0, 32'h0};
    vecs[13] = '{16'hFF00, 4'h1, 32'h00000001, 4'h0, 32'h00000005, 1'b1, 32'h1};
    vecs[14] = '{16'h0000, 4'h0, 32'h00000000, 4'hF, 32'hCAFEF00D, 1'b1, 32'h1};
    vecs[15] = '{16'h0300, 4'h0, 32'h00000000, 4'hF, 32'h5A5A5A5A, 1'b1, 32'h1};
    vecs[16] = '{16'hFF00, 4'hF, 32'h0000002A, 4'h0, 32'h5A5A5A5A, 1'b1, 32'h2A};
    vecs[17] = '{16'hFF00, 4'h0, 32'h00000000, 4'h1, 32'h5A5A5A00, 1'b1, 32'h2A};
    vecs[18] = '{16'h0020, 4'hF, 32'h01020304, 4'h0, 32'h5A5A5A00, 1'b1, 32'h2A};
    vecs[19] = '{16'h0020, 4'h1, 32'h000000FF, 4'h3, 32'h5A5A03FF, 1'b1, 32'h2A};
    vecs[20] = '{16'hFF04, 4'h0, 32'h00000000, 4'hC, 32'h000003FF, 1'b1, 32'h2A};

    rst    = 1'b1;
    dat_a  = '0;
    dat_we = '0;
    dat_wd = '0;
    dat_re = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset dat_rd", dat_rd, 32'h0);
    check("reset done", {31'b0, done}, 32'h0);
    check("reset exit_code", exit_code, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      apply(vecs[i].a, vecs[i].we, vecs[i].wd, vecs[i].re);
      check($sformatf("vec%0d dat_rd", i), dat_rd, vecs[i].rd);
      check($sformatf("vec%0d done", i), {31'b0, done}, {31'b0, vecs[i].done});
      check($sformatf("vec%0d exit_code", i), exit_code, vecs[i].exit_code);
    end

    // CYCLE wrap: preload all-ones between edges.
    force dut.r_cycle = 32'hFFFFFFFF;
    #1;
    release dut.r_cycle;
    apply(16'hFF04, 4'h0, 32'h0, 4'hF);
    check("cycle at max", dat_rd, 32'hFFFFFFFF);
    apply(16'hFF04, 4'h0, 32'h0, 4'hF);
    check("cycle wrapped", dat_rd, 32'h00000000);

    // WRCNT saturation.
    force dut.r_wrcnt = 32'hFFFFFFFF;
    #1;
    release dut.r_wrcnt;
    apply(16'h0040, 4'hF, 32'h0, 4'h0);
    apply(16'hFF08, 4'h0, 32'h0, 4'hF);
    check("wrcnt saturates", dat_rd, 32'hFFFFFFFF);

    // Reset in mid-run with done set and non-zero read data.
    apply(16'h0010, 4'h0, 32'h0, 4'hF);
    check("pre-reset read", dat_rd, 32'h11223344);
    #2;
    rst = 1'b1;
    #1;
    check("async reset dat_rd", dat_rd, 32'h0);
    check("async reset done", {31'b0, done}, 32'h0);
    check("async reset exit_code", exit_code, 32'h0);
    apply(16'h0010, 4'hF, 32'hDDDDDDDD, 4'hF);
    check("request in reset dropped", dat_rd, 32'h0);
    rst = 1'b0;
    apply(16'hFF04, 4'h0, 32'h0, 4'hF);
    check("cycle restarts", dat_rd, 32'h0);
    apply(16'h0010, 4'h0, 32'h0, 4'hF);
    check("sram persists 0x0010", dat_rd, 32'h11223344);
    apply(16'h0000, 4'h0, 32'h0, 4'hF);
    check("sram persists 0x0000", dat_rd, 32'hCAFEF00D);
    apply(16'hFF08, 4'h0, 32'h0, 4'hF);
    check("wrcnt cleared", dat_rd, 32'h0);
    check("done after reset", {31'b0, done}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
